// File: rtl/issue_skid_reg.sv
// issue_skid_reg: LANES independent two-entry (main + skid) issue buffers.
// Each lane is a small FSM (EMPTY / ONE / TWO) with a saturating stall counter.
//
// Handshake: a transfer happens on a lane in any cycle where valid and ready
// are both high at the rising edge. in_ready depends only on the lane's state
// flop (never on out_ready), so no combinational path crosses the buffer.
// out_valid and out_data also come straight from flops.
module issue_skid_reg #(
  parameter int LANES  = 2,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANES-1:0]          in_valid,
  output logic [LANES-1:0]          in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic [LANES-1:0]          out_valid,
  input  logic [LANES-1:0]          out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  input  logic [LANES-1:0]          flush,
  input  logic                      clr_stats,
  output logic [LANES*CNT_W-1:0]    stall_cnt,
  // Lane i state at bits [2*i +: 2]: 0 = EMPTY, 1 = ONE, 2 = TWO.
  output logic [2*LANES-1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } lane_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_state_e        state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc;
    logic               rel;
    logic [DATA_W-1:0]  din;

    assign din = in_data[i*DATA_W +: DATA_W];

    // Handshake decode; ready/valid come from the state flop only.
    assign in_ready[i]  = (state_q != ST_TWO);
    assign out_valid[i] = (state_q != ST_EMPTY);
    assign acc          = in_valid[i] & in_ready[i];
    assign rel          = out_valid[i] & out_ready[i];

    // Next-state and payload movement; flush wins over any handshake.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_ONE;
            main_d  = din;
          end
        end
        ST_ONE: begin
          if (acc && rel) begin
            main_d = din;
          end else if (acc) begin
            state_d = ST_TWO;
            skid_d  = din;
          end else if (rel) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end
        end
        ST_TWO: begin
          if (rel) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
      if (flush[i]) begin
        state_d = ST_EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    end

    // Stall counter: count valid-but-not-ready cycles, saturate, clear wins.
    always_comb begin
      cnt_d = cnt_q;
      if (out_valid[i] && !out_ready[i] && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (clr_stats) begin
        cnt_d = '0;
      end
    end

    // Lane state, payload and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        cnt_q   <= cnt_d;
      end
    end

    assign out_data[i*DATA_W +: DATA_W] = main_q;
    assign stall_cnt[i*CNT_W +: CNT_W]  = cnt_q;
    assign dbg_state[2*i +: 2]          = state_q;
  end

endmodule

// File: tb/tb_issue_skid_reg.sv
// Bench for issue_skid_reg: directed vector table, hand-written corner
// sequences, then randomized traffic against a per-lane queue model.
module tb_issue_skid_reg;

  localparam int LANES  = 2;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset;
  logic [LANES-1:0]        in_valid, in_ready, out_valid, out_ready, flush;
  logic [LANES*DATA_W-1:0] in_data, out_data;
  logic                    clr_stats;
  logic [LANES*CNT_W-1:0]  stall_cnt;
  logic [2*LANES-1:0]      dbg_state;

  issue_skid_reg #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .clr_stats (clr_stats),
    .stall_cnt (stall_cnt),
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard / reference model ----------------
  logic [DATA_W-1:0] exp_q [LANES][$];
  int                mcnt  [LANES];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_all(input string nm, input logic [1:0] e_irdy, input logic [1:0] e_ov,
                           input logic [15:0] e_od, input logic [7:0] e_st);
    chk({nm, ".in_ready"},  64'(in_ready),  64'(e_irdy));
    chk({nm, ".out_valid"}, 64'(out_valid), 64'(e_ov));
    chk({nm, ".out_data"},  64'(out_data),  64'(e_od));
    chk({nm, ".stall_cnt"}, 64'(stall_cnt), 64'(e_st));
  endtask

  // Model rule: a lane is a FIFO of capacity 2; head is visible downstream.
  task automatic model_update();
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        exp_q[l].delete();
        mcnt[l] = 0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        int sz;
        sz = exp_q[l].size();
        if (flush[l]) begin
          exp_q[l].delete();
        end else begin
          if (sz > 0 && out_ready[l]) void'(exp_q[l].pop_front());
          if (in_valid[l] && sz < 2) exp_q[l].push_back(in_data[l*DATA_W +: DATA_W]);
        end
        if (clr_stats) mcnt[l] = 0;
        else if (sz > 0 && !out_ready[l] && mcnt[l] < CMAX) mcnt[l]++;
      end
    end
  endtask

  task automatic model_check(input string nm);
    logic [1:0]  e_irdy, e_ov;
    logic [15:0] e_od;
    logic [7:0]  e_st;
    e_irdy = '0; e_ov = '0; e_od = '0; e_st = '0;
    for (int l = 0; l < LANES; l++) begin
      int sz;
      sz = exp_q[l].size();
      e_irdy[l] = (sz < 2);
      e_ov[l]   = (sz > 0);
      if (sz > 0) e_od[l*DATA_W +: DATA_W] = exp_q[l][0];
      e_st[l*CNT_W +: CNT_W] = 4'(mcnt[l]);
    end
    check_all(nm, e_irdy, e_ov, e_od, e_st);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [1:0] iv, input logic [15:0] id,
                       input logic [1:0] ordy, input logic [1:0] fl, input logic clr);
    reset = r; in_valid = iv; in_data = id; out_ready = ordy; flush = fl; clr_stats = clr;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    drive(1'b0, 2'b00, 16'h0000, 2'b11, 2'b00, 1'b0);
    step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [1:0]  iv;
    logic [15:0] id;
    logic [1:0]  ordy;
    logic [1:0]  fl;
    logic        clr;
    logic [1:0]  e_irdy;
    logic [1:0]  e_ov;
    logic [15:0] e_od;
    logic [7:0]  e_st;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [1:0] iv, input logic [15:0] id, input logic [1:0] ordy,
                              input logic clr, input logic [1:0] e_irdy, input logic [1:0] e_ov,
                              input logic [15:0] e_od, input logic [7:0] e_st);
    vec_t v;
    v.rst = 1'b0; v.iv = iv; v.id = id; v.ordy = ordy; v.fl = 2'b00; v.clr = clr;
    v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_od = e_od; v.e_st = e_st;
    return v;
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    // Lane 0 streaming, then lane 0 back-pressure filling the skid entry.
    vecs[0] = mk(2'b01, 16'h0011, 2'b11, 1'b0, 2'b11, 2'b01, 16'h0011, 8'h00);
    vecs[1] = mk(2'b01, 16'h0022, 2'b11, 1'b0, 2'b11, 2'b01, 16'h0022, 8'h00);
    vecs[2] = mk(2'b01, 16'h0033, 2'b11, 1'b0, 2'b11, 2'b01, 16'h0033, 8'h00);
    vecs[3] = mk(2'b00, 16'h0000, 2'b11, 1'b0, 2'b11, 2'b00, 16'h0000, 8'h00);
    vecs[4] = mk(2'b01, 16'h00A1, 2'b10, 1'b0, 2'b11, 2'b01, 16'h00A1, 8'h00);
    vecs[5] = mk(2'b01, 16'h00A2, 2'b10, 1'b0, 2'b10, 2'b01, 16'h00A1, 8'h01);
    vecs[6] = mk(2'b00, 16'h0000, 2'b10, 1'b0, 2'b10, 2'b01, 16'h00A1, 8'h02);
    vecs[7] = mk(2'b00, 16'h0000, 2'b11, 1'b0, 2'b11, 2'b01, 16'h00A2, 8'h02);
    vecs[8] = mk(2'b00, 16'h0000, 2'b11, 1'b0, 2'b11, 2'b00, 16'h0000, 8'h02);
    vecs[9] = mk(2'b00, 16'h0000, 2'b11, 1'b1, 2'b11, 2'b00, 16'h0000, 8'h00);

    // Reset state
    drive(1'b1, 2'b00, 16'h0000, 2'b00, 2'b00, 1'b0);
    step();
    step();
    check_all("reset", 2'b11, 2'b00, 16'h0000, 8'h00);
    chk("reset.dbg_state", 64'(dbg_state), 64'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl, vecs[i].clr);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_irdy, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_st);
    end

    // Flush of lane 1 while full, with a payload offered in the same cycle.
    drive(1'b0, 2'b11, 16'hB155, 2'b01, 2'b00, 1'b0); step();
    check_all("flush.fill1", 2'b11, 2'b11, 16'hB155, 8'h00);
    drive(1'b0, 2'b10, 16'hB200, 2'b01, 2'b00, 1'b0); step();
    check_all("flush.fill2", 2'b01, 2'b10, 16'hB100, 8'h10);
    drive(1'b0, 2'b11, 16'hB366, 2'b01, 2'b10, 1'b0); step();
    check_all("flush.hit", 2'b11, 2'b01, 16'h0066, 8'h20);
    idle_step();
    check_all("flush.after1", 2'b11, 2'b00, 16'h0000, 8'h20);
    idle_step();
    check_all("flush.after2", 2'b11, 2'b00, 16'h0000, 8'h20);

    // Counter saturation and clear.
    drive(1'b1, 2'b00, 16'h0000, 2'b11, 2'b00, 1'b0); step();
    drive(1'b0, 2'b01, 16'h0077, 2'b10, 2'b00, 1'b0); step();
    chk("sat.start", 64'(stall_cnt[CNT_W-1:0]), 64'h0);
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 2'b00, 16'h0000, 2'b10, 2'b00, 1'b0); step();
      chk($sformatf("sat.k%0d", k), 64'(stall_cnt[CNT_W-1:0]), 64'((k > CMAX) ? CMAX : k));
    end
    drive(1'b0, 2'b00, 16'h0000, 2'b10, 2'b00, 1'b1); step();
    chk("sat.clr", 64'(stall_cnt), 64'h0);
    drive(1'b0, 2'b00, 16'h0000, 2'b10, 2'b00, 1'b0); step();
    chk("sat.resume", 64'(stall_cnt), 64'h1);
    idle_step();
    check_all("sat.drain", 2'b11, 2'b00, 16'h0000, 8'h01);

    // Reset mid-operation overrides flush, clr and handshakes.
    drive(1'b0, 2'b11, 16'hD1C1, 2'b00, 2'b00, 1'b0); step();
    drive(1'b0, 2'b01, 16'h00C2, 2'b00, 2'b00, 1'b0); step();
    chk("rst.pre_irdy", 64'(in_ready), 64'h2);
    drive(1'b1, 2'b11, 16'hEEEE, 2'b11, 2'b11, 1'b1); step();
    check_all("rst.mid", 2'b11, 2'b00, 16'h0000, 8'h00);
    chk("rst.mid_dbg", 64'(dbg_state), 64'h0);

    // Randomized traffic against the queue model.
    for (int c = 0; c < 10000; c++) begin
      model_check("rnd");
      drive(($urandom_range(0, 499) == 0),
            2'($urandom_range(0, 3)),
            16'($urandom),
            {($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1)},
            {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)},
            ($urandom_range(0, 49) == 0));
      step();
    end
    model_check("rnd.end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_skid_reg.md
ISSUE_SKID_REG -- requirements
Module: issue_skid_reg

Interface
REQ-001 SHALL have parameter LANES, default 2, number of independent issue lanes (1..8).
REQ-002 SHALL have parameter DATA_W, default 64, payload bits per lane.
REQ-003 SHALL have parameter CNT_W, default 16, width of each per-lane stall counter.
REQ-004 SHALL have port clk  input  1  single clock; all flops update on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  LANES  upstream payload valid, bit i = lane i.
REQ-007 SHALL have port in_ready  output  LANES  lane i can accept a payload.
REQ-008 SHALL have port in_data  input  LANES*DATA_W  lane i payload at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port out_valid  output  LANES  downstream payload valid.
REQ-010 SHALL have port out_ready  input  LANES  downstream accepts lane i.
REQ-011 SHALL have port out_data  output  LANES*DATA_W  lane i payload, same packing as in_data.
REQ-012 SHALL have port flush  input  LANES  discard all contents of lane i.
REQ-013 SHALL have port clr_stats  input  1  clear all stall counters.
REQ-014 SHALL have port stall_cnt  output  LANES*CNT_W  lane i counter at bits [i*CNT_W +: CNT_W].

Function
REQ-015 SHALL implement each lane as an independent 2-entry buffer (main, skid); lanes SHALL NOT interact.
REQ-016 SHALL give each lane states EMPTY (none valid), ONE (main valid), TWO (main+skid valid).
REQ-017 SHALL accept on lane i when in_valid[i] and in_ready[i]; SHALL release when out_valid[i] and out_ready[i].
REQ-018 SHALL drive in_ready[i] = 1 in EMPTY/ONE, 0 in TWO, decoded from state flops only (no combinational path from out_ready).
REQ-019 SHALL drive out_valid[i] = 1 in ONE/TWO; out_data[i] = main entry, zero when EMPTY.
REQ-020 EMPTY: accept -> ONE, main <= in_data; else stay.
REQ-021 ONE: accept+release -> ONE, main <= in_data; accept only -> TWO, skid <= in_data; release only -> EMPTY; neither -> stay.
REQ-022 TWO: release -> ONE, main <= skid, skid cleared; else stay; no accept possible.
REQ-023 SHALL preserve per-lane order: payloads leave in acceptance order, none duplicated or lost without flush.
REQ-024 SHALL give latency of exactly 1 cycle from accept in EMPTY to out_valid.
REQ-025 flush[i] SHALL force lane i to EMPTY next cycle, main and skid zeroed, overriding any simultaneous accept or release; a payload offered in the flush cycle SHALL be dropped.
REQ-026 SHALL increment stall_cnt[i] each cycle out_valid[i]=1 and out_ready[i]=0, saturating at 2^CNT_W-1 (no wrap).
REQ-027 clr_stats SHALL zero all counters next cycle, overriding a simultaneous increment; flush SHALL NOT affect counters.

Reset
REQ-028 reset SHALL set every lane EMPTY, main/skid 0, out_valid 0, out_data 0, stall_cnt 0, in_ready all 1 from the first cycle after reset.
REQ-029 reset SHALL override flush, clr_stats and any handshake in the same cycle; reset mid-operation SHALL drop all buffered payloads.

Verification
REQ-030 LANES=2, DATA_W=8: lane0 in 0x11,0x22,0x33 on consecutive cycles, out_ready[0]=1 -> out 0x11,0x22,0x33 one cycle later each, in_ready[0] stays 1.
REQ-031 Lane0 out_ready=0, offer 0xA1 then 0xA2 -> state TWO, in_ready[0]=0, stall_cnt0 counts; out_ready=1 -> 0xA1 then 0xA2, in_ready[0] returns 1 after first release.
REQ-032 Lane1 in TWO with 0xB1/0xB2, assert flush[1] together with in_valid[1]=1 data 0xB3 -> next cycle out_valid[1]=0, out_data lane1=0, 0xB3 never appears; lane0 traffic unaffected.
REQ-033 CNT_W=4, hold lane0 valid with out_ready=0 for 20 cycles -> stall_cnt0 reaches 15 and stays; clr_stats pulse -> 0 next cycle, then resumes at 1.
REQ-034 Lane0 in TWO, lane1 in ONE, assert reset -> next cycle all out_valid 0, out_data 0, stall_cnt 0, in_ready=2'b11.
REQ-035 Random in_valid/out_ready/flush on all lanes for 10k cycles against a per-lane FIFO model -> exact order match, no loss except flushed entries, in_ready never 1 in TWO.
